sd_dat_tx: RTL and testbench
============================

Name: sd_dat_tx

Overview:
- Downstream consumer of the 1024x4 block RAM.
- Reads one 512-byte block from the RAM as 1024 sequential nibbles and frames it onto the 4-bit SD DAT bus.
- Frame: start nibble, 1024 data nibbles, one CRC16 per line, end nibble.
- Sits between the RAM (holding cipher output) and the SD pad drivers; the command/control FSM triggers it with a one-cycle start pulse.

Parameters:
- addr_width, 10, RAM address width; block length is 1<<addr_width nibbles.
- data_width, 4, bus width; fixed at 4, one CRC16 per line.

Ports:
- iclk  input  1  system clock; one DAT nibble per cycle.
- irst  input  1  synchronous active-high reset.
- istart  input  1  one-cycle pulse; starts a frame when idle.
- irdata  input  4  RAM read data (RAM odout); valid one cycle after the address.
- oaddr  output  10  RAM read address (drives RAM iaddr; RAM iwrite_en tied low by the owner).
- odat  output  4  DAT[3:0] value.
- odat_oe  output  1  DAT output enable.
- obusy  output  1  high while the frame is in progress.
- odone  output  1  one-cycle pulse at frame end.

Behaviour:
- One clock (iclk); reset is synchronous and active-high (irst).
- Reset values (also applied when irst is asserted mid-frame, which aborts the frame immediately, with no done pulse):
  - state=IDLE, oaddr=0, odat=4'hF, odat_oe=0, obusy=0, odone=0, CRC registers=0.
- States: IDLE -> START -> DATA -> CRC -> END -> IDLE.
- IDLE:
  - odat=F, oe=0, oaddr=0.
  - istart=1 at edge T -> START from T.
  - istart outside IDLE is ignored.
- START (1 cycle, cycle T+1):
  - odat=0000, oe=1, obusy=1.
  - oaddr=0 is presented so the RAM outputs nibble 0 in cycle T+2.
  - oaddr increments to 1 at the end of START.
- DATA (1024 cycles, T+2..T+1025):
  - odat=irdata (combinational pass-through in this state only).
  - oaddr increments every cycle; it leads the data by one, so in DATA cycle k oaddr=k+1.
  - oaddr wraps 1023->0 on the last cycle, which is harmless, and is forced to 0 on leaving DATA.
  - Nibble bit i goes to DAT[i]; address 0 is sent first.
- CRC update, per line i, every DATA cycle, with d=irdata[i]:
  - CRC16-CCITT, G=x^16+x^12+x^5+1, init 0.
  - fb=crc[15]^d; crc={crc[14:0],1'b0} ^ (fb ? 16'h1021 : 0).
- CRC state (16 cycles, T+1026..T+1041):
  - Cycle j: odat[i]=crc_i[15-j], MSB first; the CRC shifts left.
- END (1 cycle, T+1042): odat=1111, oe=1.
- Return to IDLE (cycle T+1043): odone=1 for exactly 1 cycle, obusy=0, oe=0, odat=F, CRCs cleared.
- Total frame: 1042 driven cycles.
- istart in the same cycle that odone fires is accepted (back-to-back frames).
- All outputs except odat during DATA are registered.

Optional Feature:
- Macro SD_DAT_TX_BUSY_WAIT_EN.
- Defined:
  - Adds input idat0 (1 bit, card DAT0 level).
  - After END, the block enters a WAIT state with oe=0 and obusy=1.
  - It skips 8 cycles (the card's CRC status token, ignored), then stays in WAIT while idat0=0 (card busy).
  - On the first cycle with idat0=1 it goes to IDLE with an odone pulse.
  - irst aborts WAIT like any other state.
- Not defined:
  - No idat0 port and no WAIT state.
  - odone fires directly after END, as specified above.

Test Plan:
- All-zero RAM, istart at T -> odat=0000 at T+1; 1024 nibbles 0; CRC all 0x0000 on every line; 1111 at T+1042; odone at T+1043 only.
- RAM[1023]=4'h1, rest 0 -> line0 CRC 0x1021 (bits 0001 0000 0010 0001 on DAT0); lines 1..3 CRC 0x0000.
- RAM[k]=k[3:0] -> odat in DATA cycle k equals k[3:0]; oaddr=k+1 in that cycle; per-line CRCs match a bit-serial reference model.
- Control edge cases:
  - istart pulsed mid-DATA -> ignored; frame length unchanged.
  - istart in the odone cycle -> second frame starts cleanly with CRCs reinitialised.
- irst asserted at DATA cycle 500 -> next cycle: IDLE, oe=0, odat=F, oaddr=0, no odone; a following istart gives a normal full frame.
- BUSY_WAIT_EN: idat0 held 0 for 40 cycles after END+8 -> obusy stays 1; odone pulses the cycle after idat0 rises.

Source files
------------

// File: rtl/sd_dat_tx_if.sv
// SD DAT transmit bus: frame trigger, RAM read port and DAT pad signals.
// With SD_DAT_TX_BUSY_WAIT_EN defined, it also carries the card DAT0 level (idat0).
interface sd_dat_tx_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4
);
  logic              istart;
  logic [DATA_W-1:0] irdata;
  logic [ADDR_W-1:0] oaddr;
  logic [DATA_W-1:0] odat;
  logic              odat_oe;
  logic              obusy;
  logic              odone;
`ifdef SD_DAT_TX_BUSY_WAIT_EN
  logic              idat0;
`endif

  modport master (
`ifdef SD_DAT_TX_BUSY_WAIT_EN
    input  idat0,
`endif
    input  istart, irdata,
    output oaddr, odat, odat_oe, obusy, odone
  );

  modport slave (
`ifdef SD_DAT_TX_BUSY_WAIT_EN
    output idat0,
`endif
    output istart, irdata,
    input  oaddr, odat, odat_oe, obusy, odone
  );
endinterface

// File: rtl/sd_dat_tx.sv
// Frames one RAM block onto the 4-bit SD DAT bus: start nibble, data, per-line CRC16, end nibble.
// Optional SD_DAT_TX_BUSY_WAIT_EN adds a post-frame WAIT on card busy (DAT0 low).
module sd_dat_tx #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4
) (
  input  logic         iclk,
  input  logic         irst,
  sd_dat_tx_if.master  bus
);

  localparam logic [15:0] CRC_POLY = 16'h1021;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_CRC,
    S_END
`ifdef SD_DAT_TX_BUSY_WAIT_EN
    , S_WAIT
`endif
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [ADDR_W-1:0]       r_addr,  w_addr_nxt;
  logic [DATA_W-1:0]       r_odat,  w_odat_nxt;
  logic                    r_oe,    w_oe_nxt;
  logic                    r_busy,  w_busy_nxt;
  logic                    r_done,  w_done_nxt;
  logic [3:0]              r_cnt,   w_cnt_nxt;
  logic [DATA_W-1:0][15:0] r_crc,   w_crc_nxt;

  function automatic logic [15:0] f_crc_step(input logic [15:0] crc, input logic d);
    logic fb;
    fb = crc[15] ^ d;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

  // state and output registers
  always_ff @(posedge iclk) begin
    if (irst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_odat  <= '1;
      r_oe    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_crc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_odat  <= w_odat_nxt;
      r_oe    <= w_oe_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
      r_crc   <= w_crc_nxt;
    end
  end

  // next-state and next-register values
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_odat_nxt  = r_odat;
    w_oe_nxt    = r_oe;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_crc_nxt   = r_crc;
    case (r_state)
      S_IDLE: begin
        w_addr_nxt = '0;
        w_odat_nxt = '1;
        w_oe_nxt   = 1'b0;
        w_busy_nxt = 1'b0;
        w_crc_nxt  = '0;
        if (bus.istart) begin
          w_state_nxt = S_START;
          w_odat_nxt  = '0;
          w_oe_nxt    = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end
      S_START: begin
        w_addr_nxt  = r_addr + ADDR_W'(1);
        w_state_nxt = S_DATA;
      end
      S_DATA: begin
        for (int i = 0; i < DATA_W; i++) begin
          w_crc_nxt[i] = f_crc_step(r_crc[i], bus.irdata[i]);
        end
        w_addr_nxt = r_addr + ADDR_W'(1);
        // address leads data by one, so a wrapped address marks the last nibble
        if (r_addr == '0) begin
          w_state_nxt = S_CRC;
          w_addr_nxt  = '0;
          w_cnt_nxt   = '0;
          for (int i = 0; i < DATA_W; i++) begin
            w_odat_nxt[i] = w_crc_nxt[i][15];
          end
        end
      end
      S_CRC: begin
        for (int i = 0; i < DATA_W; i++) begin
          w_crc_nxt[i]  = {r_crc[i][14:0], 1'b0};
          w_odat_nxt[i] = r_crc[i][14];
        end
        w_cnt_nxt = r_cnt + 4'd1;
        if (r_cnt == 4'd15) begin
          w_state_nxt = S_END;
          w_odat_nxt  = '1;
        end
      end
      S_END: begin
        w_odat_nxt = '1;
        w_oe_nxt   = 1'b0;
        w_crc_nxt  = '0;
`ifdef SD_DAT_TX_BUSY_WAIT_EN
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = '0;
`else
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
`endif
      end
`ifdef SD_DAT_TX_BUSY_WAIT_EN
      S_WAIT: begin
        // first 8 cycles cover the card's CRC status token
        if (r_cnt < 4'd8) begin
          w_cnt_nxt = r_cnt + 4'd1;
        end else if (bus.idat0) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.oaddr   = r_addr;
  assign bus.odat    = (r_state == S_DATA) ? bus.irdata : r_odat;
  assign bus.odat_oe = r_oe;
  assign bus.obusy   = r_busy;
  assign bus.odone   = r_done;

endmodule

// File: tb/tb_sd_dat_tx.sv
// Randomized scoreboard bench for sd_dat_tx: expected per-cycle bus state is queued at frame start.
module tb_sd_dat_tx;

  localparam int AW    = 10;
  localparam int NNIB  = 1 << AW;
`ifdef SD_DAT_TX_BUSY_WAIT_EN
  localparam int WAITN = 9;
`else
  localparam int WAITN = 0;
`endif
  localparam int NENT  = 1 + NNIB + 16 + 1 + WAITN + 1;

  typedef struct packed {
    logic          oe;
    logic [3:0]    dat;
    logic          busy;
    logic          done;
    logic [AW-1:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic mon_en = 1'b0;
  logic [3:0] mem [NNIB];
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  sd_dat_tx_if #(.ADDR_W(AW), .DATA_W(4)) bus ();

  sd_dat_tx #(.ADDR_W(AW), .DATA_W(4)) dut (
    .iclk (clk),
    .irst (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // RAM with one cycle read latency
  always @(posedge clk) bus.irdata <= mem[bus.oaddr];

  // CRC of one DAT line as the remainder of M(x)*x^16 divided by G(x)
  function automatic logic [15:0] line_crc(input int line);
    logic [16:0] rem;
    logic b;
    rem = '0;
    for (int k = 0; k < NNIB + 16; k++) begin
      b = (k < NNIB) ? mem[k][line] : 1'b0;
      rem = {rem[15:0], b};
      if (rem[16]) rem = rem ^ 17'h11021;
    end
    return rem[15:0];
  endfunction

  task automatic push_frame();
    exp_t e;
    logic [15:0] crc [4];
    for (int i = 0; i < 4; i++) crc[i] = line_crc(i);
    e = '{oe: 1'b1, dat: 4'h0, busy: 1'b1, done: 1'b0, addr: '0};
    q.push_back(e);
    for (int k = 0; k < NNIB; k++) begin
      e.dat  = mem[k];
      e.addr = AW'((k + 1) % NNIB);
      q.push_back(e);
    end
    e.addr = '0;
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 4; i++) e.dat[i] = crc[i][15 - j];
      q.push_back(e);
    end
    e.dat = 4'hF;
    q.push_back(e);
    e.oe = 1'b0;
    for (int w = 0; w < WAITN; w++) q.push_back(e);
    e.busy = 1'b0;
    e.done = 1'b1;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // leaves the bench in the START cycle with the frame queued
  task automatic issue_start();
    bus.istart = 1'b1;
    tick(1);
    bus.istart = 1'b0;
    push_frame();
  endtask

  task automatic fill_random();
    for (int k = 0; k < NNIB; k++) mem[k] = 4'($urandom_range(0, 15));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      if (q.size() != 0) e = q.pop_front();
      else e = '{oe: 1'b0, dat: 4'hF, busy: 1'b0, done: 1'b0, addr: '0};
      vectors++;
      if (bus.odat_oe !== e.oe || bus.odat !== e.dat || bus.obusy !== e.busy ||
          bus.odone !== e.done || bus.oaddr !== e.addr) begin
        miscompares++;
        if (miscompares <= 20)
          $display("FAIL dat_bus t=%0t: got oe=%b dat=%h busy=%b done=%b addr=%0d, need oe=%b dat=%h busy=%b done=%b addr=%0d",
                   $time, bus.odat_oe, bus.odat, bus.obusy, bus.odone, bus.oaddr,
                   e.oe, e.dat, e.busy, e.done, e.addr);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.istart = 1'b0;
    bus.irdata = 4'h0;
`ifdef SD_DAT_TX_BUSY_WAIT_EN
    bus.idat0 = 1'b1;
`endif
    for (int k = 0; k < NNIB; k++) mem[k] = 4'h0;
    tick(3);
    mon_en = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);

    // all-zero block
    issue_start();
    tick(NENT - 1);
    tick(3);

    // single 1 in the last nibble of line 0
    mem[NNIB - 1] = 4'h1;
    issue_start();
    tick(NENT - 1);
    tick(3);

    // ramp pattern with a stray start pulse mid-data
    for (int k = 0; k < NNIB; k++) mem[k] = 4'(k);
    issue_start();
    tick(300);
    bus.istart = 1'b1;
    tick(1);
    bus.istart = 1'b0;
    tick(NENT - 1 - 301);
    tick(3);

    // back-to-back frames, second start in the done cycle
    fill_random();
    issue_start();
    tick(NENT - 1);
    issue_start();
    tick(NENT - 1);
    tick(3);

    // reset in data cycle 500, then a clean frame
    fill_random();
    issue_start();
    tick(501);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    q.delete();
    tick(3);
    fill_random();
    issue_start();
    tick(NENT - 1);
    tick(5);

    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: got %0d entries left, need 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
